// File: rtl/rom_download_sequencer.sv
// ROM download transmitter: streams bytes from a valid/ready source onto the dl_* write bus while holding the core in reset.
// Optional feature: define DL_CHECKSUM_EN to add sum_expected and checksum-verified completion.
module rom_download_sequencer #(
  parameter int unsigned IMG_BYTES  = 20480,
  parameter int unsigned RESET_HOLD = 16,
  parameter int unsigned WR_GAP     = 0,
  parameter logic        INDEX      = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
`ifdef DL_CHECKSUM_EN
  input  logic [7:0]  sum_expected,
`endif
  output logic        in_ready,
  output logic [24:0] dl_addr,
  output logic [7:0]  dl_data,
  output logic        dl_wr,
  output logic        ioctl_wr,
  output logic        ioctl_index,
  output logic        core_run,
  output logic        busy,
  output logic        done,
  output logic        error
);

  typedef enum logic [2:0] {IDLE, HOLD, STREAM, GAP, RELEASE, DONE, ERROR} state_e;

  localparam logic [25:0] IMG_LEN   = 26'(IMG_BYTES);
  localparam logic [31:0] HOLD_LOAD = (RESET_HOLD == 0) ? 32'd0 : 32'(RESET_HOLD - 1);
  localparam logic [31:0] GAP_LOAD  = (WR_GAP == 0) ? 32'd0 : 32'(WR_GAP - 1);

  state_e      state_q, state_d;
  logic [31:0] timer_q, timer_d;
  logic [24:0] count_q, count_d;
  logic [24:0] dlAddr_q, dlAddr_d;
  logic [7:0]  dlData_q, dlData_d;
  logic        dlWr_q, dlWr_d;
  logic        coreRun_q, coreRun_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
`ifdef DL_CHECKSUM_EN
  logic        error_q, error_d;
  logic [7:0]  sum_q, sum_d;
  logic [7:0]  sumExp_q, sumExp_d;
`endif

  logic accept;
  logic lastByte;

  assign accept   = in_ready & in_valid;
  assign lastByte = ({1'b0, count_q} + 26'd1) == IMG_LEN;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      count_q   <= '0;
      dlAddr_q  <= '0;
      dlData_q  <= '0;
      dlWr_q    <= 1'b0;
      coreRun_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef DL_CHECKSUM_EN
      error_q   <= 1'b0;
      sum_q     <= '0;
      sumExp_q  <= '0;
`endif
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      count_q   <= count_d;
      dlAddr_q  <= dlAddr_d;
      dlData_q  <= dlData_d;
      dlWr_q    <= dlWr_d;
      coreRun_q <= coreRun_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
`ifdef DL_CHECKSUM_EN
      error_q   <= error_d;
      sum_q     <= sum_d;
      sumExp_q  <= sumExp_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    count_d   = count_q;
    dlAddr_d  = dlAddr_q;
    dlData_d  = dlData_q;
    dlWr_d    = 1'b0;
    coreRun_d = coreRun_q;
    busy_d    = busy_q;
    done_d    = done_q;
`ifdef DL_CHECKSUM_EN
    error_d   = error_q;
    sum_d     = sum_q;
    sumExp_d  = sumExp_q;
`endif
    case (state_q)
      IDLE, DONE, ERROR: begin
        if (start) begin
          coreRun_d = 1'b0;
          busy_d    = 1'b1;
          done_d    = 1'b0;
          count_d   = '0;
          timer_d   = HOLD_LOAD;
`ifdef DL_CHECKSUM_EN
          error_d   = 1'b0;
          sum_d     = '0;
          sumExp_d  = sum_expected;
`endif
          state_d   = (RESET_HOLD == 0) ? STREAM : HOLD;
        end
      end
      HOLD: begin
        if (timer_q == 32'd0) state_d = STREAM;
        else                  timer_d = timer_q - 32'd1;
      end
      STREAM: begin
        // The write lands one cycle after the handshake, addressed by the pre-increment count
        if (accept) begin
          dlWr_d   = 1'b1;
          dlAddr_d = count_q;
          dlData_d = in_data;
          count_d  = count_q + 25'd1;
`ifdef DL_CHECKSUM_EN
          sum_d    = sum_q + in_data;
`endif
          if (lastByte) begin
            state_d = RELEASE;
            timer_d = HOLD_LOAD;
          end else if (WR_GAP != 0) begin
            state_d = GAP;
            timer_d = GAP_LOAD;
          end
        end
      end
      GAP: begin
        if (timer_q == 32'd0) state_d = STREAM;
        else                  timer_d = timer_q - 32'd1;
      end
      RELEASE: begin
        if (timer_q == 32'd0) begin
          busy_d = 1'b0;
`ifdef DL_CHECKSUM_EN
          if (sum_q != sumExp_q) begin
            error_d = 1'b1;
            state_d = ERROR;
          end else
`endif
          begin
            coreRun_d = 1'b1;
            done_d    = 1'b1;
            state_d   = DONE;
          end
        end else begin
          timer_d = timer_q - 32'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state_q == STREAM);
  end

  assign dl_addr     = dlAddr_q;
  assign dl_data     = dlData_q;
  assign dl_wr       = dlWr_q;
  assign ioctl_wr    = dlWr_q;
  assign ioctl_index = INDEX;
  assign core_run    = coreRun_q;
  assign busy        = busy_q;
  assign done        = done_q;
`ifdef DL_CHECKSUM_EN
  assign error       = error_q;
`else
  assign error       = 1'b0;
`endif

endmodule

// File: tb/tb_rom_download_sequencer.sv
// Directed bench for rom_download_sequencer: three instances cover back-to-back, gapped and throttled streams.
// Checksum vectors run only when DL_CHECKSUM_EN is defined.
module tb_rom_download_sequencer;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  logic        startA, inValidA, inReadyA, dlWrA, ioctlWrA, ioctlIndexA, coreRunA, busyA, doneA, errorA;
  logic [7:0]  inDataA, dlDataA;
  logic [24:0] dlAddrA;
  logic        startB, inValidB, inReadyB, dlWrB, ioctlWrB, ioctlIndexB, coreRunB, busyB, doneB, errorB;
  logic [7:0]  inDataB, dlDataB;
  logic [24:0] dlAddrB;
  logic        startC, inValidC, inReadyC, dlWrC, ioctlWrC, ioctlIndexC, coreRunC, busyC, doneC, errorC;
  logic [7:0]  inDataC, dlDataC;
  logic [24:0] dlAddrC;
`ifdef DL_CHECKSUM_EN
  logic [7:0]  sumExpA, sumExpB, sumExpC;
`endif

  rom_download_sequencer #(.IMG_BYTES(4), .RESET_HOLD(2), .WR_GAP(0), .INDEX(1'b0)) dutA (
    .clk(clk), .rst(rst), .start(startA), .in_valid(inValidA), .in_data(inDataA),
`ifdef DL_CHECKSUM_EN
    .sum_expected(sumExpA),
`endif
    .in_ready(inReadyA), .dl_addr(dlAddrA), .dl_data(dlDataA), .dl_wr(dlWrA), .ioctl_wr(ioctlWrA),
    .ioctl_index(ioctlIndexA), .core_run(coreRunA), .busy(busyA), .done(doneA), .error(errorA)
  );

  rom_download_sequencer #(.IMG_BYTES(4), .RESET_HOLD(2), .WR_GAP(3), .INDEX(1'b1)) dutB (
    .clk(clk), .rst(rst), .start(startB), .in_valid(inValidB), .in_data(inDataB),
`ifdef DL_CHECKSUM_EN
    .sum_expected(sumExpB),
`endif
    .in_ready(inReadyB), .dl_addr(dlAddrB), .dl_data(dlDataB), .dl_wr(dlWrB), .ioctl_wr(ioctlWrB),
    .ioctl_index(ioctlIndexB), .core_run(coreRunB), .busy(busyB), .done(doneB), .error(errorB)
  );

  rom_download_sequencer #(.IMG_BYTES(16), .RESET_HOLD(2), .WR_GAP(0), .INDEX(1'b0)) dutC (
    .clk(clk), .rst(rst), .start(startC), .in_valid(inValidC), .in_data(inDataC),
`ifdef DL_CHECKSUM_EN
    .sum_expected(sumExpC),
`endif
    .in_ready(inReadyC), .dl_addr(dlAddrC), .dl_data(dlDataC), .dl_wr(dlWrC), .ioctl_wr(ioctlWrC),
    .ioctl_index(ioctlIndexC), .core_run(coreRunC), .busy(busyC), .done(doneC), .error(errorC)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Full 4-byte download on dutA; leaves the bench one cycle before core_run should rise
  task automatic applyStimulus(input logic [31:0] bytes);
    startA   = 1'b1;
    inValidA = 1'b1;
    inDataA  = bytes[7:0];
    tick();
    startA = 1'b0;
    checkOutput("busyAfterStart", 32'(busyA), 32'd1);
    checkOutput("coreHeldAfterStart", 32'(coreRunA), 32'd0);
    checkOutput("readyHold0", 32'(inReadyA), 32'd0);
    tick();
    checkOutput("readyHold1", 32'(inReadyA), 32'd0);
    tick();
    checkOutput("readyRise", 32'(inReadyA), 32'd1);
    for (int i = 0; i < 4; i++) begin
      inDataA = bytes[8*i +: 8];
      tick();
      checkOutput("strobeWr", 32'(dlWrA), 32'd1);
      checkOutput("strobeIoctl", 32'(ioctlWrA), 32'd1);
      checkOutput("strobeAddr", 32'(dlAddrA), 32'(i));
      checkOutput("strobeData", 32'(dlDataA), 32'(bytes[8*i +: 8]));
      checkOutput("coreHeldStream", 32'(coreRunA), 32'd0);
    end
    inValidA = 1'b0;
    checkOutput("readyLowRelease", 32'(inReadyA), 32'd0);
    tick();
    checkOutput("strobeEnds", 32'(dlWrA), 32'd0);
    checkOutput("coreHeldRelease", 32'(coreRunA), 32'd0);
    checkOutput("doneLowRelease", 32'(doneA), 32'd0);
  endtask

  initial begin
    int lastStrobe;
    int strobes;
    int ioctlDiff;
    int pushCount;
    bit doneSeen;
    bit handshake;

    vectors = 0;
    miscompares = 0;
    rst = 1'b1;
    startA = 1'b0; inValidA = 1'b1; inDataA = 8'h99;
    startB = 1'b0; inValidB = 1'b0; inDataB = 8'h00;
    startC = 1'b0; inValidC = 1'b1; inDataC = 8'h00;
`ifdef DL_CHECKSUM_EN
    sumExpA = 8'hAA; sumExpB = 8'h68; sumExpC = 8'h78;
`endif

    $display("[TB] reset values");
    tick();
    checkOutput("rstAddr", 32'(dlAddrA), 32'd0);
    checkOutput("rstData", 32'(dlDataA), 32'd0);
    checkOutput("rstWr", 32'(dlWrA), 32'd0);
    checkOutput("rstIoctl", 32'(ioctlWrA), 32'd0);
    checkOutput("rstReady", 32'(inReadyA), 32'd0);
    checkOutput("rstReadyC", 32'(inReadyC), 32'd0);
    checkOutput("rstCoreRun", 32'(coreRunA), 32'd0);
    checkOutput("rstBusy", 32'(busyA), 32'd0);
    checkOutput("rstDone", 32'(doneA), 32'd0);
    checkOutput("rstError", 32'(errorA), 32'd0);
    checkOutput("indexA", 32'(ioctlIndexA), 32'd0);
    checkOutput("indexB", 32'(ioctlIndexB), 32'd1);
    rst = 1'b0;
    tick();
    checkOutput("idleReady", 32'(inReadyA), 32'd0);

    $display("[TB] back-to-back download 11 22 33 44");
    applyStimulus(32'h44332211);
    tick();
    checkOutput("coreRunRise", 32'(coreRunA), 32'd1);
    checkOutput("doneRise", 32'(doneA), 32'd1);
    checkOutput("busyFall", 32'(busyA), 32'd0);
    checkOutput("errorClear", 32'(errorA), 32'd0);
    inValidA = 1'b1;
    inDataA  = 8'h55;
    checkOutput("readyAfterDone", 32'(inReadyA), 32'd0);
    tick();
    checkOutput("noWriteAfterDone", 32'(dlWrA), 32'd0);
    checkOutput("addrHeld", 32'(dlAddrA), 32'd3);
    checkOutput("dataHeld", 32'(dlDataA), 32'h44);
    inValidA = 1'b0;

    $display("[TB] gapped stream WR_GAP=3");
    startB = 1'b1; inValidB = 1'b1; inDataB = 8'h5A;
    tick();
    startB = 1'b0;
    lastStrobe = -1; strobes = 0; ioctlDiff = 0;
    for (int cyc = 1; cyc <= 30; cyc++) begin
      tick();
      if (ioctlWrB !== dlWrB) ioctlDiff++;
      if (dlWrB === 1'b1) begin
        if (strobes == 0) checkOutput("gapFirstStrobe", 32'(cyc), 32'd3);
        else              checkOutput("gapSpacing", 32'(cyc - lastStrobe), 32'd4);
        checkOutput("gapAddr", 32'(dlAddrB), 32'(strobes));
        lastStrobe = cyc;
        strobes++;
      end
    end
    checkOutput("gapStrobeCount", 32'(strobes), 32'd4);
    checkOutput("gapIoctlCopy", 32'(ioctlDiff), 32'd0);
    checkOutput("gapDone", 32'(doneB), 32'd1);
    checkOutput("gapCoreRun", 32'(coreRunB), 32'd1);
    inValidB = 1'b0;

    $display("[TB] throttled stream IMG_BYTES=16");
    startC = 1'b1; inValidC = 1'b0;
    tick();
    startC = 1'b0;
    strobes = 0; pushCount = 0; doneSeen = 1'b0;
    for (int cyc = 0; cyc < 300 && !doneSeen; cyc++) begin
      inValidC  = 1'($urandom_range(0, 1));
      inDataC   = 8'hC0 + 8'(pushCount);
      startC    = (cyc == 20 || cyc == 33);
      handshake = inReadyC && inValidC;
      tick();
      if (handshake) pushCount++;
      if (dlWrC === 1'b1) begin
        checkOutput("thrAddr", 32'(dlAddrC), 32'(strobes));
        checkOutput("thrData", 32'(dlDataC), 32'(8'hC0 + 8'(strobes)));
        checkOutput("thrIoctl", 32'(ioctlWrC), 32'd1);
        strobes++;
      end
      if (doneC === 1'b1) doneSeen = 1'b1;
    end
    startC = 1'b0;
    inValidC = 1'b1;
    checkOutput("thrStrobeCount", 32'(strobes), 32'd16);
    checkOutput("thrDone", 32'(doneC), 32'd1);
    checkOutput("thrReadyAfter", 32'(inReadyC), 32'd0);
    inValidC = 1'b0;

    $display("[TB] reset mid-transfer then restart");
`ifdef DL_CHECKSUM_EN
    sumExpA = 8'h8A;
`endif
    startA = 1'b1; inValidA = 1'b1; inDataA = 8'hA1;
    tick();
    startA = 1'b0;
    checkOutput("midCoreHeld", 32'(coreRunA), 32'd0);
    tick();
    tick();
    tick();
    checkOutput("midAddr0", 32'(dlAddrA), 32'd0);
    inDataA = 8'hA2;
    tick();
    checkOutput("midAddr1", 32'(dlAddrA), 32'd1);
    inValidA = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("midRstWr", 32'(dlWrA), 32'd0);
    checkOutput("midRstAddr", 32'(dlAddrA), 32'd0);
    checkOutput("midRstCore", 32'(coreRunA), 32'd0);
    checkOutput("midRstBusy", 32'(busyA), 32'd0);
    tick();
    checkOutput("midIdleCore", 32'(coreRunA), 32'd0);
    applyStimulus(32'hA4A3A2A1);
    tick();
    checkOutput("restartCoreRun", 32'(coreRunA), 32'd1);
    checkOutput("restartDone", 32'(doneA), 32'd1);

`ifdef DL_CHECKSUM_EN
    $display("[TB] checksum match and mismatch");
    sumExpA = 8'h0A;
    applyStimulus(32'h04030201);
    tick();
    checkOutput("sumOkDone", 32'(doneA), 32'd1);
    checkOutput("sumOkError", 32'(errorA), 32'd0);
    checkOutput("sumOkCore", 32'(coreRunA), 32'd1);
    sumExpA = 8'h0B;
    applyStimulus(32'h04030201);
    tick();
    checkOutput("sumBadError", 32'(errorA), 32'd1);
    checkOutput("sumBadDone", 32'(doneA), 32'd0);
    checkOutput("sumBadCore", 32'(coreRunA), 32'd0);
    checkOutput("sumBadBusy", 32'(busyA), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
